mor1kx_wb32_sram_slave: RTL and testbench



---
 rtl/mor1kx_wb32_sram_slave.sv | 128 ++++++++++++
 tb/tb_mor1kx_wb32_sram_slave.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_wb32_sram_slave.sv
// mor1kx_wb32_sram_slave: Wishbone B3 32-bit slave backed by a single-port synchronous RAM.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wbs_adr_i[31:0]   byte address (bits [1:0] ignored)
//   wbs_dat_i[31:0]   write data
//   wbs_sel_i[3:0]    byte lane enables, bit 3 = dat[31:24]
//   wbs_we_i          write enable
//   wbs_stb_i         strobe
//   wbs_cyc_i         cycle valid
//   wbs_cti_i[2:0]    cycle type (000 classic, 010 incrementing burst, 111 end of burst)
//   wbs_bte_i[1:0]    burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16)
//   wbs_dat_o[31:0]   read data
//   wbs_ack_o         transfer acknowledge
//   wbs_err_o         out-of-range error
//   wbs_rty_o         retry, tied low
// Build option: define WB_SLAVE_BURST_EN for registered-feedback burst support;
// without it every transfer is classic and cti/bte are ignored.
module mor1kx_wb32_sram_slave #(
  parameter int MEM_WORDS = 1024,
  parameter int MEM_AW = 10,
  parameter MEM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o
);
  typedef enum logic [1:0] {IDLE, CLASSIC, BURST, WAIT} state_t;
  state_t state_q, state_d;
  logic ack_q, ack_d, err_q, err_d, req, in_range, fresh, ram_we;
  logic [MEM_AW-1:0] wadr, rd_addr;
  logic [29:0] adr_q;
  logic [31:0] ram [MEM_WORDS];
  assign req = wbs_cyc_i & wbs_stb_i;
  assign wadr = wbs_adr_i[MEM_AW+1:2];
  assign in_range = wbs_adr_i[31:MEM_AW+2] == '0;
  // a held strobe on the same address after an ack is not a new request
  assign fresh = req && (state_q == IDLE || wbs_adr_i[31:2] != adr_q);
  assign wbs_ack_o = ack_q & req;
  assign wbs_err_o = err_q & req;
  assign wbs_rty_o = 1'b0;
`ifdef WB_SLAVE_BURST_EN
  logic [MEM_AW-1:0] cnt_q, cnt_d, cnt_inc, wmask;
  logic hit, beat_ack, ovf, unused_ok;
  assign unused_ok = ^wbs_adr_i[1:0];
  assign wmask = wbs_bte_i == 2'b01 ? MEM_AW'(3) : wbs_bte_i == 2'b10 ? MEM_AW'(7) : MEM_AW'(15);
  assign cnt_inc = wbs_bte_i == 2'b00 ? cnt_q + MEM_AW'(1) : (cnt_q & ~wmask) | ((cnt_q + MEM_AW'(1)) & wmask);
  assign hit = req && wbs_adr_i[31:2] == 30'(cnt_q);
  // cnt always names the beat whose ack is currently on the bus
  assign beat_ack = ack_q & hit;
  assign ovf = wbs_bte_i == 2'b00 && &cnt_q;
  always_ff @(posedge clk) cnt_q <= cnt_d;
`else
  logic unused_ok;
  assign unused_ok = ^{wbs_cti_i, wbs_bte_i, wbs_adr_i[1:0]};
`endif
  always_comb begin
    state_d = state_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    ram_we = 1'b0;
    rd_addr = wadr;
`ifdef WB_SLAVE_BURST_EN
    cnt_d = cnt_q;
    if (state_q == BURST) begin
      rd_addr = cnt_q;
      if (!wbs_cyc_i || (req && !hit)) state_d = IDLE;
      else if (beat_ack) begin
        ram_we = wbs_we_i;
        if (wbs_cti_i == 3'b111) state_d = IDLE;
        else if (ovf) begin
          state_d = IDLE;
          err_d = 1'b1;
        end else begin
          ack_d = 1'b1;
          cnt_d = cnt_inc;
          rd_addr = cnt_inc;
        end
      end else ack_d = hit;
    end else
`endif
    if (fresh) begin
      if (!in_range) begin
        err_d = 1'b1;
        state_d = WAIT;
      end
`ifdef WB_SLAVE_BURST_EN
      else if (wbs_cti_i == 3'b010) begin
        ack_d = 1'b1;
        cnt_d = wadr;
        state_d = BURST;
      end
`endif
      else begin
        ack_d = 1'b1;
        ram_we = wbs_we_i;
        state_d = CLASSIC;
      end
    end else state_d = req ? WAIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
    adr_q <= wbs_adr_i[31:2];
  end
  always_ff @(posedge clk) begin
    wbs_dat_o <= rst ? '0 : ram[rd_addr];
    for (int b = 0; b < 4; b++)
      if (!rst && ram_we && wbs_sel_i[b]) ram[wadr][8*b +: 8] <= wbs_dat_i[8*b +: 8];
  end
endmodule

// File: tb/tb_mor1kx_wb32_sram_slave.sv
// tb_mor1kx_wb32_sram_slave: directed self-checking bench for the Wishbone SRAM slave.
module tb_mor1kx_wb32_sram_slave;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0, dat_i = '0, dat_o;
  logic [3:0] sel = '0;
  logic we = 1'b0, stb = 1'b0, cyc = 1'b0, ack, err, rty;
  logic [2:0] cti = '0;
  logic [1:0] bte = '0;
  int checks = 0, passed = 0;
  logic [31:0] badr [8];
  logic [31:0] bdat [8];
`ifdef WB_SLAVE_BURST_EN
  localparam bit BURST_BUILD = 1'b1;
`else
  localparam bit BURST_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  mor1kx_wb32_sram_slave dut (
    .clk(clk), .rst(rst), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_sel_i(sel),
    .wbs_we_i(we), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty)
  );

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = '0; bte = '0;
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int lat, output logic ak, output logic er);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s; cti = '0; bte = '0;
    lat = -1; ak = 1'b0; er = 1'b0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack || err) begin
        lat = i; ak = ack; er = err; rd = dat_o;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic burst(input int n, input logic [1:0] bt, input int stall_after,
                       output int nack, output int stall_acks, output int last_cyc);
    int beat = 0;
    int cn = 0;
    nack = 0; stall_acks = 0; last_cyc = -1;
    cyc = 1'b1; we = 1'b0; sel = 4'hf; bte = bt;
    while (beat < n && cn < 64) begin
      stb = 1'b1; adr = badr[beat]; cti = beat == n - 1 ? 3'b111 : 3'b010;
      @(negedge clk);
      if (ack) begin
        bdat[beat] = dat_o; nack++; last_cyc = cn; beat++;
        if (beat - 1 == stall_after)
          for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            stb = 1'b0; cn++;
            @(negedge clk);
            if (ack) stall_acks++;
          end
      end
      @(posedge clk); #1;
      cn++;
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ack); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    checks++; if (dat_o !== 32'h0) $display("FAIL reset_dat: got %h want 00000000", dat_o); else passed++;
    checks++; if (rty !== 1'b0) $display("FAIL reset_rty: got %b want 0", rty); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_classic();
    logic [31:0] rd; int lat; logic ak, er; logic [3:0] pat;
    xfer(1'b1, 32'h40, 32'hDEADBEEF, 4'hf, rd, lat, ak, er);
    checks++; if (ak !== 1'b1 || lat != 1) $display("FAIL classic_wr: got ack=%b lat=%0d want ack=1 lat=1", ak, lat); else passed++;
    xfer(1'b0, 32'h40, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (lat != 1) $display("FAIL classic_rd_lat: got %0d want 1", lat); else passed++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL classic_rd_dat: got %h want deadbeef", rd); else passed++;
    xfer(1'b1, 32'h44, 32'h01234567, 4'hf, rd, lat, ak, er);
    xfer(1'b0, 32'h44, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'h01234567) $display("FAIL classic_rd44: got %h want 01234567", rd); else passed++;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h40; pat = '0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = ack;
      if (ack) rd = dat_o;
      @(posedge clk); #1;
    end
    idle_bus();
    @(posedge clk); #1;
    checks++; if (pat !== 4'b0010) $display("FAIL held_stb_acks: got %b want 0010", pat); else passed++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL held_stb_dat: got %h want deadbeef", rd); else passed++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int lat; logic ak, er;
    xfer(1'b1, 32'h40, 32'h000000AA, 4'b0001, rd, lat, ak, er);
    xfer(1'b0, 32'h40, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'hDEADBEAA) $display("FAIL lane0: got %h want deadbeaa", rd); else passed++;
    xfer(1'b1, 32'h40, 32'h11000000, 4'b1000, rd, lat, ak, er);
    xfer(1'b0, 32'h40, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'h11ADBEAA) $display("FAIL lane3: got %h want 11adbeaa", rd); else passed++;
    xfer(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, rd, lat, ak, er);
    checks++; if (ak !== 1'b1) $display("FAIL sel0_ack: got %b want 1", ak); else passed++;
    xfer(1'b0, 32'h40, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'h11ADBEAA) $display("FAIL sel0_dat: got %h want 11adbeaa", rd); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat; logic ak, er;
    xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'hf, rd, lat, ak, er);
    xfer(1'b1, 32'h1000, 32'h0BADBAD0, 4'hf, rd, lat, ak, er);
    checks++; if (er !== 1'b1 || ak !== 1'b0 || lat != 1) $display("FAIL oor_wr: got err=%b ack=%b lat=%0d want err=1 ack=0 lat=1", er, ak, lat); else passed++;
    xfer(1'b0, 32'h0, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'hCAFEF00D) $display("FAIL oor_no_alias: got %h want cafef00d", rd); else passed++;
    xfer(1'b0, 32'h80000000, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (er !== 1'b1 || ak !== 1'b0) $display("FAIL oor_rd_high: got err=%b ack=%b want err=1 ack=0", er, ak); else passed++;
  endtask

  task automatic preload();
    logic [31:0] rd; int lat; logic ak, er;
    for (int w = 4; w < 16; w++) xfer(1'b1, 32'(w * 4), 32'hA5000000 | 32'(w * 4), 4'hf, rd, lat, ak, er);
  endtask

  task automatic test_wrap4();
    int nack, sa, last; logic [31:0] rd; int lat; logic ak, er;
    badr[0] = 32'h18; badr[1] = 32'h1C; badr[2] = 32'h10; badr[3] = 32'h14;
    burst(4, 2'b01, -1, nack, sa, last);
    checks++; if (nack != 4) $display("FAIL wrap4_acks: got %0d want 4", nack); else passed++;
    checks++; if (last != (BURST_BUILD ? 4 : 7)) $display("FAIL wrap4_last_cycle: got %0d want %0d", last, BURST_BUILD ? 4 : 7); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bdat[i] !== (32'hA5000000 | badr[i])) $display("FAIL wrap4_dat%0d: got %h want %h", i, bdat[i], 32'hA5000000 | badr[i]); else passed++;
    end
    xfer(1'b0, 32'h20, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (lat != 1 || rd !== 32'hA5000020) $display("FAIL after_burst_rd: got lat=%0d dat=%h want lat=1 dat=a5000020", lat, rd); else passed++;
  endtask

  task automatic test_burst_stall();
    int nack, sa, last;
    badr[0] = 32'h34; badr[1] = 32'h38; badr[2] = 32'h3C; badr[3] = 32'h20;
    badr[4] = 32'h24; badr[5] = 32'h28; badr[6] = 32'h2C; badr[7] = 32'h30;
    burst(8, 2'b10, 2, nack, sa, last);
    checks++; if (nack != 8) $display("FAIL stall_acks_total: got %0d want 8", nack); else passed++;
    checks++; if (sa != 0) $display("FAIL stall_acks_during: got %0d want 0", sa); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bdat[i] !== (32'hA5000000 | badr[i])) $display("FAIL stall_dat%0d: got %h want %h", i, bdat[i], 32'hA5000000 | badr[i]); else passed++;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a [3]; int beat; logic ak_b, er_b; logic [31:0] rd; int lat; logic ak, er;
    a[0] = 32'h28; a[1] = 32'h2C; a[2] = 32'h30; beat = 0;
    cyc = 1'b1; we = 1'b1; sel = 4'hf; bte = 2'b10;
    for (int i = 0; i < 16 && beat < 2; i++) begin
      stb = 1'b1; adr = a[beat]; dat_i = 32'h5A000000 | a[beat]; cti = 3'b010;
      @(negedge clk);
      if (ack) beat++;
      @(posedge clk); #1;
    end
    adr = a[2]; dat_i = 32'h5A000030; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0; cti = 3'b111;
    @(negedge clk);
    ak_b = ack; er_b = err;
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    checks++; if (beat != 2) $display("FAIL rstb_beats: got %0d want 2", beat); else passed++;
    checks++; if (ak_b !== 1'b0 || er_b !== 1'b0) $display("FAIL rstb_outputs: got ack=%b err=%b want 0 0", ak_b, er_b); else passed++;
    xfer(1'b0, 32'h28, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'h5A000028) $display("FAIL rstb_beat0: got %h want 5a000028", rd); else passed++;
    xfer(1'b0, 32'h2C, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'h5A00002C) $display("FAIL rstb_beat1: got %h want 5a00002c", rd); else passed++;
    xfer(1'b0, 32'h30, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'hA5000030) $display("FAIL rstb_beat2: got %h want a5000030", rd); else passed++;
    xfer(1'b0, 32'h34, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'hA5000034) $display("FAIL rstb_beat3: got %h want a5000034", rd); else passed++;
  endtask

  task automatic test_linear_overflow();
    logic [31:0] rd, d0; int lat, first, acks_after; logic ak, er, got_err;
    first = -1; acks_after = 0; got_err = 1'b0; d0 = '0;
    xfer(1'b1, 32'hFFC, 32'h77777777, 4'hf, rd, lat, ak, er);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hFFC; cti = 3'b010; bte = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) begin
        first = i; d0 = dat_o;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    adr = 32'h1000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks_after++;
      if (err) begin
        got_err = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    checks++; if (first != 1) $display("FAIL ovf_first_lat: got %0d want 1", first); else passed++;
    checks++; if (d0 !== 32'h77777777) $display("FAIL ovf_first_dat: got %h want 77777777", d0); else passed++;
    checks++; if (got_err !== 1'b1) $display("FAIL ovf_err: got %b want 1", got_err); else passed++;
    checks++; if (acks_after != 0) $display("FAIL ovf_extra_acks: got %0d want 0", acks_after); else passed++;
  endtask

  task automatic test_reset_wins();
    logic [31:0] rd; int lat; logic ak, er;
    xfer(1'b1, 32'h80, 32'h11111111, 4'hf, rd, lat, ak, er);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h80; dat_i = 32'h22222222; sel = 4'hf; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b0) $display("FAIL rst_req_ack: got %b want 0", ack); else passed++;
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk); #1;
    xfer(1'b0, 32'h80, 32'h0, 4'hf, rd, lat, ak, er);
    checks++; if (rd !== 32'h11111111) $display("FAIL rst_req_nowrite: got %h want 11111111", rd); else passed++;
  endtask

  initial begin
    test_reset();
    test_classic();
    test_byte_lanes();
    test_out_of_range();
    preload();
    test_wrap4();
    test_burst_stall();
    test_reset_mid_burst();
    test_linear_overflow();
    test_reset_wins();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
